// File: rtl/id_ex_skid_reg.sv
// id_ex_skid_reg: two-entry skid buffer between the decode and execute stages.
// The head entry ("main") drives the execute-side outputs. The second entry
// ("skid") absorbs one payload while execute stalls, so in_ready can stay
// registered and never depends combinationally on out_ready.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   decode-side handshake (in_ready registered)
//   in_data, in_ctrl    packed {rd1, rd2, pc, imm, pc_plus4, rd, rs1, rs2} and control bundle
//   flush               discard all held entries (branch/jump redirect)
//   out_valid/out_ready execute-side handshake (out_valid registered)
//   out_data, out_ctrl  head payload; out_ctrl is forced to zero when no entry is valid
//   flush_cnt           saturating count of valid entries discarded by flush
module id_ex_skid_reg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned CTRLW = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [5*XLEN+3*AW-1:0]   in_data,
    input  logic [CTRLW-1:0]         in_ctrl,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [5*XLEN+3*AW-1:0]   out_data,
    output logic [CTRLW-1:0]         out_ctrl,
    output logic [15:0]              flush_cnt
);

    localparam int unsigned DW   = 5*XLEN + 3*AW;
    localparam int unsigned CNTW = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     main_data_q, main_data_d;
    logic [DW-1:0]     skid_data_q, skid_data_d;
    logic [CTRLW-1:0]  skid_ctrl_q, skid_ctrl_d;
    // out_ctrl_q doubles as the head control storage; it is zero whenever empty.
    logic [CTRLW-1:0]  out_ctrl_q, out_ctrl_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [CNTW-1:0]   flush_cnt_q, flush_cnt_d;

    logic              fire_in;
    logic              fire_out;
    logic [1:0]        held;
    logic [1:0]        discard;
    logic [CNTW:0]     cnt_sum;

    // Next-state, payload movement and flush accounting.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        out_ctrl_d  = out_ctrl_q;
        flush_cnt_d = flush_cnt_q;

        fire_in  = in_valid && in_ready_q;
        fire_out = out_valid_q && out_ready;

        case (state_q)
            ONE:     held = 2'd1;
            TWO:     held = 2'd2;
            default: held = 2'd0;
        endcase
        // An entry leaving on the flush edge was delivered, not discarded.
        discard = held - 2'(fire_out);
        cnt_sum = {1'b0, flush_cnt_q} + (CNTW+1)'(discard);

        if (flush) begin
            state_d     = EMPTY;
            flush_cnt_d = cnt_sum[CNTW] ? {CNTW{1'b1}} : cnt_sum[CNTW-1:0];
        end else begin
            case (state_q)
                EMPTY: begin
                    if (fire_in) begin
                        state_d     = ONE;
                        main_data_d = in_data;
                        out_ctrl_d  = in_ctrl;
                    end
                end
                ONE: begin
                    if (fire_in && !fire_out) begin
                        state_d     = TWO;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (fire_in && fire_out) begin
                        main_data_d = in_data;
                        out_ctrl_d  = in_ctrl;
                    end else if (fire_out) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (fire_out) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        out_ctrl_d  = skid_ctrl_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // Bubble control when empty; out_data simply keeps its last value.
        if (state_d == EMPTY) begin
            out_ctrl_d = '0;
        end
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != TWO);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            out_ctrl_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            out_ctrl_q  <= out_ctrl_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = out_ctrl_q;
    assign flush_cnt = flush_cnt_q;

endmodule
